fft_seq_ctrl: RTL and testbench
===============================

Name: fft_seq_ctrl

Overview:
Sequencer for the radix-2 DIT in-place ping-pong FFT datapath: butterfly unit, RE/IM bank 0/1, twiddle ROM.
Runs each frame in order: sample load into bank 0, then LOG2N butterfly stages with per-stage drain, then result unload.
Generates every RAM address, twiddle index, bank select and handshake. Contains no arithmetic on sample data.

Parameters:
LOG2N, 6, log2 of FFT points (N = 2**LOG2N = 64)
PIPE_LAT, 2, cycles from butterfly accept to write-back in the datapath (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a frame; sampled only in IDLE
busy  out  1  high in any state other than IDLE
in_valid  in  1  input sample present (LOAD only)
ld_we  out  1  bank-0 write enable = in_valid & (state==LOAD)
ld_addr  out  LOG2N  bank-0 write address
bf_valid  out  1  butterfly request
bf_ready  in  1  datapath accepts butterfly
bf_top  out  LOG2N  upper operand address
bf_bot  out  LOG2N  lower operand address
bf_tw  out  LOG2N-1  twiddle ROM index
bf_stage  out  3  current stage m
bf_rd_bank  out  1  read bank = m[0]; write bank is its inverse
out_valid  out  1  result word valid
out_ready  in  1  consumer accepts
out_addr  out  LOG2N  result read address
out_bank  out  1  result bank = LOG2N[0]
out_last  out  1  high with the final result word
done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All counters, state and registered outputs return to 0 on reset, state goes to IDLE.
- States: IDLE, LOAD, CALC, DRAIN, UNLOAD, FIN.
- IDLE: on start=1, go to LOAD. Clear sample counter c, stage m, group i, offset j.
- LOAD: each cycle with in_valid=1 writes one sample and increments c.
  - Go to CALC on the cycle after the write with c=N-1.
  - in_valid=0 stalls the counter.
- CALC, butterfly (m, i, j) with half = 1<<m:
  - bf_top = i*2*half + j; bf_bot = bf_top + half; bf_tw = j << (LOG2N-1-m).
  - bf_valid stays high in CALC. Addresses hold while bf_ready=0.
  - On each bf_valid & bf_ready, advance j. On j wrap (j=half-1), reset j and advance i.
  - After the last butterfly of the stage (i = N/(2*half)-1, j = half-1) is accepted, go to DRAIN.
- DRAIN: bf_valid=0 for exactly PIPE_LAT cycles so the stage write-back completes before the next stage reads.
  - Then, if m < LOG2N-1: m++, i=j=0, return to CALC.
  - Otherwise go to UNLOAD with c=0.
- UNLOAD: out_valid=1, out_addr=c, out_bank=LOG2N[0].
  - c increments on out_valid & out_ready.
  - out_last=1 when c=N-1. Its acceptance moves the block to FIN.
- FIN: done=1 for one cycle, then IDLE.
- Outputs by state:
  - bf_* address outputs are driven combinationally from the counters. bf_valid is 0 outside CALC.
  - out_valid is 0 outside UNLOAD.
  - ld_we is 0 outside LOAD.
- Boundaries and events:
  - start while busy is ignored.
  - start and in_valid on the same cycle in IDLE: that sample is not written; LOAD begins next cycle.
  - rst_n deasserted mid-frame abandons the frame. No done pulse; RAM contents are undefined.
  - All counters are exactly LOG2N (or LOG2N-1) bits wide. Wrap-around is detected by compare, never by overflow.
- Timing: with bf_ready=out_ready=in_valid=1 and defaults, start→done = 1 + 64 + 6*(32+2) + 64 + 1 = 334 cycles.

Optional Feature:
FFT_SEQ_BITREV_EN.
- Defined: ld_addr = bit-reverse of c over LOG2N bits. Natural-order input yields a correct DIT result.
- Undefined: ld_addr = c. The upstream source delivers samples already in bit-reversed order.
- Macro affects only ld_addr.

Decomposition:
- Package fft_pkg:
  - FFT_LOG2N, FFT_N, FFT_PIPE_LAT.
  - State enum localparams.
  - Address width constants.
  - A bit-reverse function, also reused by testbenches.
- One sub-module, fft_bf_addr_gen: combinational (m,i,j)→(top, bot, tw), separately unit-testable.
- The FSM and counters stay in fft_seq_ctrl.

Test Plan:
- Reset, then start with in_valid=1 for 64 cycles: ld_addr runs 0..63 (bitrev: 0,32,16,48,…); no bf_valid during LOAD.
- Stage checks with bf_ready=1:
  - Stage 0, first two butterflies: (top,bot,tw) = (0,1,0), (2,3,0).
  - Stage 1, second butterfly: (1,3,16).
  - Stage 5, second butterfly: (1,33,1), bf_rd_bank=1.
- bf_ready toggled 1/0 every cycle: addresses hold on stalled cycles. Exactly 192 accepts occur, with a 2-cycle bf_valid=0 gap after each stage's 32nd accept.
- out_ready low for 5 cycles mid-unload (c=10): out_addr holds at 10; out_last only at 63; done one cycle after that accept. With all handshakes held high, start→done = 334 cycles.
- Robustness:
  - start pulsed during CALC: no effect.
  - rst_n low at stage 3: busy=0 and all valids=0 immediately (asynchronous); no done.
  - A new start then completes a full frame normally.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, state encoding and bit-reverse helper for the FFT sequencer.
package fft_pkg;

    localparam int unsigned FFT_LOG2N    = 6;
    localparam int unsigned FFT_N        = 1 << FFT_LOG2N;
    localparam int unsigned FFT_PIPE_LAT = 2;
    localparam int unsigned FFT_AW       = FFT_LOG2N;
    localparam int unsigned FFT_TW       = FFT_LOG2N - 1;
    localparam int unsigned FFT_SW       = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_DRAIN,
        ST_UNLOAD,
        ST_FIN
    } fft_state_e;

    // Reverses the low w bits of x (w <= 8); bits at and above w are returned as zero.
    function automatic logic [7:0] bitrev(input logic [7:0] x, input int unsigned w);
        logic [7:0] r;
        r = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < w) r[3'(k)] = x[3'(w - 1 - k)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational butterfly address map: (stage m, group i, offset j) -> (top, bot, twiddle).
module fft_bf_addr_gen
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = FFT_LOG2N
) (
    input  logic [2:0]       m,
    input  logic [LOG2N-2:0] i,
    input  logic [LOG2N-2:0] j,
    output logic [LOG2N-1:0] top,
    output logic [LOG2N-1:0] bot,
    output logic [LOG2N-2:0] tw
);

    logic [LOG2N-1:0] half;

    // j < half and i is shifted past it, so OR composes i*2*half + j without a carry chain.
    always_comb begin
        half = {{(LOG2N-1){1'b0}}, 1'b1} << m;
        top  = ({1'b0, i} << ({1'b0, m} + 4'd1)) | {1'b0, j};
        bot  = top + half;
        tw   = j << (3'(LOG2N - 1) - m);
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Radix-2 DIT ping-pong FFT sequencer: load, LOG2N stages with drain, unload.
// FFT_SEQ_BITREV_EN: when defined, ld_addr is the bit-reverse of the load counter.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N    = FFT_LOG2N,
    parameter int unsigned PIPE_LAT = FFT_PIPE_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    input  logic             in_valid,
    output logic             ld_we,
    output logic [LOG2N-1:0] ld_addr,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] bf_top,
    output logic [LOG2N-1:0] bf_bot,
    output logic [LOG2N-2:0] bf_tw,
    output logic [2:0]       bf_stage,
    output logic             bf_rd_bank,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOG2N-1:0] out_addr,
    output logic             out_bank,
    output logic             out_last,
    output logic             done
);

    localparam int unsigned HW = LOG2N - 1;
    localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [LOG2N-1:0] C_LAST = {LOG2N{1'b1}};
    localparam logic [2:0]       M_LAST = 3'(LOG2N - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(PIPE_LAT - 1);
    localparam logic [HW-1:0]    ONE_H  = {{(HW-1){1'b0}}, 1'b1};

    fft_state_e       state_q, state_d;
    logic [LOG2N-1:0] c_q, c_d;
    logic [2:0]       m_q, m_d;
    logic [HW-1:0]    i_q, i_d;
    logic [HW-1:0]    j_q, j_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             busy_q, busy_d;
    logic             bf_valid_q, bf_valid_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;

    logic [HW-1:0]    j_last;
    logic [HW-1:0]    i_last;

    // half-1 and N/(2*half)-1; at the top stage the shift overflows to 0 and the subtract wraps to all-ones.
    always_comb begin
        j_last = (ONE_H << m_q) - ONE_H;
        i_last = {HW{1'b1}} >> m_q;
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        m_d     = m_q;
        i_d     = i_q;
        j_d     = j_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    c_d     = '0;
                    m_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (c_q == C_LAST) begin
                        c_d     = '0;
                        state_d = ST_CALC;
                    end else begin
                        c_d = c_q + LOG2N'(1);
                    end
                end
            end
            ST_CALC: begin
                if (bf_ready) begin
                    if (j_q == j_last) begin
                        j_d = '0;
                        if (i_q == i_last) begin
                            i_d     = '0;
                            dcnt_d  = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            i_d = i_q + ONE_H;
                        end
                    end else begin
                        j_d = j_q + ONE_H;
                    end
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == D_LAST) begin
                    dcnt_d = '0;
                    if (m_q == M_LAST) begin
                        c_d     = '0;
                        state_d = ST_UNLOAD;
                    end else begin
                        m_d     = m_q + 3'd1;
                        state_d = ST_CALC;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    if (c_q == C_LAST) begin
                        c_d     = '0;
                        state_d = ST_FIN;
                    end else begin
                        c_d = c_q + LOG2N'(1);
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d      = (state_d != ST_IDLE);
        bf_valid_d  = (state_d == ST_CALC);
        out_valid_d = (state_d == ST_UNLOAD);
        out_last_d  = (state_d == ST_UNLOAD) && (c_d == C_LAST);
        done_d      = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            c_q         <= '0;
            m_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            dcnt_q      <= '0;
            busy_q      <= 1'b0;
            bf_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            m_q         <= m_d;
            i_q         <= i_d;
            j_q         <= j_d;
            dcnt_q      <= dcnt_d;
            busy_q      <= busy_d;
            bf_valid_q  <= bf_valid_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    fft_bf_addr_gen #(
        .LOG2N(LOG2N)
    ) u_addr_gen (
        .m   (m_q),
        .i   (i_q),
        .j   (j_q),
        .top (bf_top),
        .bot (bf_bot),
        .tw  (bf_tw)
    );

    assign busy       = busy_q;
    assign ld_we      = in_valid & (state_q == ST_LOAD);
`ifdef FFT_SEQ_BITREV_EN
    assign ld_addr    = LOG2N'(bitrev(8'(c_q), LOG2N));
`else
    assign ld_addr    = c_q;
`endif
    assign bf_valid   = bf_valid_q;
    assign bf_stage   = m_q;
    assign bf_rd_bank = m_q[0];
    assign out_valid  = out_valid_q;
    assign out_addr   = c_q;
    assign out_bank   = ((LOG2N % 2) == 1);
    assign out_last   = out_last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: frame-level reference model feeds queues, a monitor checks them.
`timescale 1ns/1ps
module tb_fft_seq_ctrl;
    import fft_pkg::*;

    localparam int unsigned LG  = FFT_LOG2N;
    localparam int unsigned N   = FFT_N;
    localparam int unsigned PL  = FFT_PIPE_LAT;
    localparam int unsigned LAT = 1 + N + LG * (N / 2 + PL) + N + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          bf_ready = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, ld_we, bf_valid, bf_rd_bank, out_valid, out_bank, out_last, done;
    logic [LG-1:0] ld_addr, bf_top, bf_bot, out_addr;
    logic [LG-2:0] bf_tw;
    logic [2:0]    bf_stage;

    fft_seq_ctrl #(.LOG2N(LG), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .in_valid(in_valid), .ld_we(ld_we), .ld_addr(ld_addr),
        .bf_valid(bf_valid), .bf_ready(bf_ready), .bf_top(bf_top), .bf_bot(bf_bot),
        .bf_tw(bf_tw), .bf_stage(bf_stage), .bf_rd_bank(bf_rd_bank),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_bank(out_bank), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned top, bot, tw, stage;
        logic        bank;
        logic        stage_end;
    } bf_t;

    typedef struct {
        int unsigned addr;
        logic        last;
    } out_t;

    int unsigned ld_q[$];
    bf_t         bf_q[$];
    out_t        out_q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned bf_accepts = 0;
    int unsigned flush_gen = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: load order, every butterfly of every stage, then the unload sequence.
    task automatic push_frame();
        for (int unsigned k = 0; k < N; k++) begin
`ifdef FFT_SEQ_BITREV_EN
            ld_q.push_back(int'(bitrev(8'(k), LG)));
`else
            ld_q.push_back(k);
`endif
        end
        for (int unsigned s = 0; s < LG; s++) begin
            int unsigned half;
            half = 1 << s;
            for (int unsigned b = 0; b < N / 2; b++) begin
                bf_t e;
                int unsigned grp, off;
                grp         = b / half;
                off         = b % half;
                e.top       = grp * 2 * half + off;
                e.bot       = e.top + half;
                e.tw        = off * (N / (2 * half));
                e.stage     = s;
                e.bank      = ((s % 2) == 1);
                e.stage_end = (b == N / 2 - 1);
                bf_q.push_back(e);
            end
        end
        for (int unsigned k = 0; k < N; k++) begin
            out_t o;
            o.addr = k;
            o.last = (k == N - 1);
            out_q.push_back(o);
        end
    endtask

    initial begin : monitor
        int unsigned seen_gen;
        int          gap;
        logic        want_done;
        seen_gen  = 0;
        gap       = -1;
        want_done = 1'b0;
        forever begin
            @(negedge clk);
            if (flush_gen != seen_gen) begin
                seen_gen = flush_gen;
                ld_q.delete();
                bf_q.delete();
                out_q.delete();
                gap       = -1;
                want_done = 1'b0;
            end
            if (!rst_n) continue;

            if (want_done) begin
                chk("done_pulse", done, 1);
                want_done = 1'b0;
            end else if (done) begin
                chk("done_spurious", done, 0);
            end

            if (ld_we) begin
                chk("ld_vs_bf_valid", bf_valid, 0);
                if (ld_q.size() == 0) chk("ld_unexpected", 1, 0);
                else begin
                    chk("ld_addr", ld_addr, ld_q[0]);
                    void'(ld_q.pop_front());
                end
            end

            if (gap >= 0) begin
                if (bf_valid || out_valid) begin
                    chk("drain_gap", gap, PL);
                    gap = -1;
                end else begin
                    gap++;
                end
            end

            if (bf_valid) begin
                chk("bf_vs_out_valid", out_valid, 0);
                if (bf_q.size() == 0) chk("bf_unexpected", 1, 0);
                else begin
                    chk("bf_top", bf_top, bf_q[0].top);
                    chk("bf_bot", bf_bot, bf_q[0].bot);
                    chk("bf_tw", bf_tw, bf_q[0].tw);
                    chk("bf_stage", bf_stage, bf_q[0].stage);
                    chk("bf_rd_bank", bf_rd_bank, bf_q[0].bank);
                    if (bf_ready) begin
                        bf_accepts++;
                        if (bf_q[0].stage_end) gap = 0;
                        void'(bf_q.pop_front());
                    end
                end
            end

            if (out_valid) begin
                if (out_q.size() == 0) chk("out_unexpected", 1, 0);
                else begin
                    chk("out_addr", out_addr, out_q[0].addr);
                    chk("out_last", out_last, out_q[0].last);
                    chk("out_bank", out_bank, LG % 2);
                    if (out_ready) begin
                        if (out_q[0].last) want_done = 1'b1;
                        void'(out_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic run_frame(input bit iv_start, input bit rnd_iv, input int bf_mode,
                             input bit rnd_out, input bit stall10, input bit noise,
                             input bit abort, input bit chk_lat);
        int unsigned edges;
        int unsigned acc0;
        int          stall_left;
        bit          finished;
        bit          tog;
        edges      = 0;
        acc0       = bf_accepts;
        stall_left = -1;
        finished   = 1'b0;
        tog        = 1'b0;
        push_frame();
        start     = 1'b1;
        in_valid  = iv_start;
        bf_ready  = 1'b0;
        out_ready = 1'b0;
        while (edges < 6000 && !finished) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (abort && bf_valid && bf_stage == 3'd3) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_bf_valid", bf_valid, 0);
                chk("abort_out_valid", out_valid, 0);
                chk("abort_ld_we", ld_we, 0);
                flush_gen++;
                start    = 1'b0;
                in_valid = 1'b0;
                bf_ready = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("abort_no_done_rst", done, 0);
                end
                @(posedge clk);
                #2 rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_idle", busy, 0);
                    chk("abort_no_done", done, 0);
                end
                return;
            end
            start    = noise && busy && ($urandom_range(0, 3) == 0);
            in_valid = rnd_iv ? 1'($urandom_range(0, 1)) : 1'b1;
            case (bf_mode)
                1:       begin tog = ~tog; bf_ready = tog; end
                2:       bf_ready = 1'($urandom_range(0, 1));
                default: bf_ready = 1'b1;
            endcase
            if (stall10 && out_valid && out_addr == 10 && stall_left < 0) stall_left = 5;
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        start = 1'b0;
        chk("frame_done_seen", finished, 1);
        if (chk_lat) chk("start_to_done", edges + 1, LAT);
        if (bf_mode == 1) chk("bf_accepts", bf_accepts - acc0, LG * N / 2);
        @(negedge clk);
        @(negedge clk);
        chk("ld_q_left", ld_q.size(), 0);
        chk("bf_q_left", bf_q.size(), 0);
        chk("out_q_left", out_q.size(), 0);
        chk("idle_after_frame", busy, 0);
    endtask

    initial begin : main
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_bf_valid", bf_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_ld_we", ld_we, 0);
        chk("rst_ld_addr", ld_addr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_bf_top", bf_top, 0);
        chk("rst_bf_bot", bf_bot, 1);
        chk("rst_bf_stage", bf_stage, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // all handshakes high, in_valid together with start
        run_frame(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        // bf_ready toggling, out_ready stall at 10, start noise while busy
        run_frame(1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        // reset during stage 3
        run_frame(1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 2; r++) begin
            repeat (2) @(posedge clk);
            #1;
            run_frame(1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
